// File: rtl/alu_pkg.sv
// Shared definitions for seq_alu: op-code encodings, FSM state encoding and
// the classifier that separates single-cycle ops from iterative mul/div ops.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SLT   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_REMU  = 4'b1100;
    localparam logic [3:0] OP_SRA   = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_iterative(input logic [3:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide unit.
// One step per cycle for WIDTH cycles after start_i. Multiply and divide share
// a single adder, the step counter and the 2*WIDTH accumulator {hi, lo}.
// Ports:
//   clk, rst       clock, async active-high reset
//   start_i        load operands and begin (one-cycle pulse)
//   op_i           OP_MUL / OP_MULHU / OP_DIVU / OP_REMU
//   a_i, b_i       operands
//   done_o         high during the final step; result_o valid in that cycle
//   result_o       selected half of the post-step accumulator
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    logic                 busy_q, busy_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [3:0]           op_q, op_d;

    logic [WIDTH-1:0]     hi, lo;
    logic                 is_mul;
    logic [WIDTH:0]       add_x, add_y;
    logic [WIDTH+1:0]     sum;

    assign hi     = acc_q[2*WIDTH-1:WIDTH];
    assign lo     = acc_q[WIDTH-1:0];
    assign is_mul = (op_q == OP_MUL) || (op_q == OP_MULHU);

    // Multiply: hi + (lo[0] ? b : 0). Divide: {hi, next dividend bit} - b,
    // done as x + ~b + 1 so sum[WIDTH+1] is the no-borrow indication.
    always_comb begin
        add_x = is_mul ? {1'b0, hi} : {hi, lo[WIDTH-1]};
        if (is_mul) begin
            add_y = lo[0] ? {1'b0, b_q} : '0;
        end else begin
            add_y = ~{1'b0, b_q};
        end
        sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, ~is_mul};
    end

    always_comb begin
        if (is_mul) begin
            acc_step = {sum[WIDTH:0], lo[WIDTH-1:1]};
        end else if (sum[WIDTH+1]) begin
            acc_step = {sum[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
        end
    end

    // mul and divu take the low half (product low / quotient); mulhu and remu the high half.
    assign result_o = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? acc_step[WIDTH-1:0]
                                                              : acc_step[2*WIDTH-1:WIDTH];
    assign done_o   = busy_q && (cnt_q == '0);

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        b_d    = b_q;
        op_d   = op_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CntLast;
            acc_d  = {{WIDTH{1'b0}}, a_i};
            b_d    = b_i;
            op_d   = op_i;
        end else if (busy_q) begin
            acc_d = acc_step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            b_q    <= '0;
            op_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            b_q    <= b_d;
            op_q   <= op_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle integer ops plus iterative mul/mulhu/divu/remu.
// Result and flags are registered and held until the consumer takes them.
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   alu_a, alu_b, alu_op  operands and op code, captured at acceptance
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   alu_f, zf, sf, cf, of registered result and flags
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_f,
    output logic             zf,
    output logic             sf,
    output logic             cf,
    output logic             of
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_e state_q, state_d;

    logic             accept, iter_op, iter_done;
    logic [WIDTH-1:0] iter_result;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_sum, sub_dif;
    logic [WIDTH-1:0] sc_f;
    logic             sc_cf, sc_of;

    logic [WIDTH-1:0] f_q, f_d, ld_f;
    logic             zf_q, zf_d, sf_q, sf_d, cf_q, cf_d, of_q, of_d;
    logic             load, ld_cf, ld_of;

    assign accept  = (state_q == IDLE) && in_valid;
    assign iter_op = is_iterative(alu_op);

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept && iter_op),
        .op_i    (alu_op),
        .a_i     (alu_a),
        .b_i     (alu_b),
        .done_o  (iter_done),
        .result_o(iter_result)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = iter_op ? BUSY : DONE;
            BUSY:    if (iter_done) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Single-cycle datapath
    assign shamt   = alu_b[SHW-1:0];
    assign add_sum = {1'b0, alu_a} + {1'b0, alu_b};
    assign sub_dif = {1'b0, alu_a} - {1'b0, alu_b};

    always_comb begin
        sc_f  = '0;
        sc_cf = 1'b0;
        sc_of = 1'b0;
        case (alu_op)
            OP_ADD: begin
                sc_f  = add_sum[WIDTH-1:0];
                sc_cf = add_sum[WIDTH];
                sc_of = (alu_a[MSB] == alu_b[MSB]) && (sc_f[MSB] != alu_a[MSB]);
            end
            OP_SUB: begin
                sc_f  = sub_dif[WIDTH-1:0];
                sc_cf = sub_dif[WIDTH];  // borrow out == A <u B
                sc_of = (alu_a[MSB] != alu_b[MSB]) && (sc_f[MSB] != alu_a[MSB]);
            end
            OP_SLL:  sc_f = alu_a << shamt;
            OP_SRL:  sc_f = alu_a >> shamt;
            OP_SRA:  sc_f = $signed(alu_a) >>> shamt;
            OP_SLT:  sc_f = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            OP_SLTU: sc_f = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
            OP_XOR:  sc_f = alu_a ^ alu_b;
            OP_OR:   sc_f = alu_a | alu_b;
            OP_AND:  sc_f = alu_a & alu_b;
            default: sc_f = '0;
        endcase
    end

    // Result/flag registers load once per op: at acceptance or on the last iteration.
    always_comb begin
        load  = 1'b0;
        ld_f  = '0;
        ld_cf = 1'b0;
        ld_of = 1'b0;
        if (accept && !iter_op) begin
            load  = 1'b1;
            ld_f  = sc_f;
            ld_cf = sc_cf;
            ld_of = sc_of;
        end else if ((state_q == BUSY) && iter_done) begin
            load = 1'b1;
            ld_f = iter_result;
        end
        f_d  = f_q;
        zf_d = zf_q;
        sf_d = sf_q;
        cf_d = cf_q;
        of_d = of_q;
        if (load) begin
            f_d  = ld_f;
            zf_d = (ld_f == '0);
            sf_d = ld_f[MSB];
            cf_d = ld_cf;
            of_d = ld_of;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q  <= '0;
            zf_q <= 1'b0;
            sf_q <= 1'b0;
            cf_q <= 1'b0;
            of_q <= 1'b0;
        end else begin
            f_q  <= f_d;
            zf_q <= zf_d;
            sf_q <= sf_d;
            cf_q <= cf_d;
            of_q <= of_d;
        end
    end

    assign alu_f = f_q;
    assign zf    = zf_q;
    assign sf    = sf_q;
    assign cf    = cf_q;
    assign of    = of_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        iv32, ir32, ov32, ordy32, zf32, sf32, cf32, of32;
    logic [31:0] a32, b32, f32;
    logic [3:0]  op32;
    // 8-bit instance
    logic        iv8, ir8, ov8, ordy8, zf8, sf8, cf8, of8;
    logic [7:0]  a8, b8, f8;
    logic [3:0]  op8;

    seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .alu_a(a32), .alu_b(b32), .alu_op(op32),
        .out_valid(ov32), .out_ready(ordy32), .alu_f(f32),
        .zf(zf32), .sf(sf32), .cf(cf32), .of(of32)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .alu_a(a8), .alu_b(b8), .alu_op(op8),
        .out_valid(ov8), .out_ready(ordy8), .alu_f(f8),
        .zf(zf8), .sf(sf8), .cf(cf8), .of(of8)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint sext(input logic [63:0] v, input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        if (v[w-1]) return longint'(v | ~m);
        return longint'(v & m);
    endfunction

    // Returns {zf, sf, cf, of, f[31:0]}
    function automatic logic [35:0] model(input int w, input logic [3:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] m, r;
        longint      sa, sb, s, maxs, mins;
        int          sh;
        logic        c, o;
        m    = (64'd1 << w) - 64'd1;
        sa   = sext(a, w);
        sb   = sext(b, w);
        maxs = (longint'(1) <<< (w - 1)) - 1;
        mins = -maxs - 1;
        sh   = int'(b % 64'(w));
        c    = 1'b0;
        o    = 1'b0;
        r    = '0;
        case (op)
            4'd0: begin
                r = a + b;
                c = r[w];
                s = sa + sb;
                o = (s > maxs) || (s < mins);
            end
            4'd8: begin
                r = a - b;
                c = (a < b);
                s = sa - sb;
                o = (s > maxs) || (s < mins);
            end
            4'd1:  r = a << sh;
            4'd5:  r = a >> sh;
            4'd13: r = 64'(sa >>> sh);
            4'd2:  r = {63'd0, sa < sb};
            4'd3:  r = {63'd0, a < b};
            4'd4:  r = a ^ b;
            4'd6:  r = a | b;
            4'd7:  r = a & b;
            4'd9:  r = a * b;
            4'd10: r = (a * b) >> w;
            4'd11: r = (b == 0) ? m : a / b;
            4'd12: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        r = r & m;
        return {(r == 64'd0), r[w-1], c, o, r[31:0]};
    endfunction

    function automatic int exp_lat(input int w, input logic [3:0] op);
        return (op >= 4'd9 && op <= 4'd12) ? w : 0;
    endfunction

    // ---------------- transaction driver ----------------
    // sel=0 drives the 32-bit instance, sel=1 the 8-bit instance.
    task automatic txn(input bit sel, input string name, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ef, input logic [3:0] efl, input int elat);
        int n;
        int lat;
        @(negedge clk);
        n = 0;
        while (!(sel ? ir8 : ir32) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, " in_ready"}, 64'(sel ? ir8 : ir32), 64'd1);
        if (sel) begin
            iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; op8 = op; ordy8 = 1'b0;
        end else begin
            iv32 = 1'b1; a32 = a; b32 = b; op32 = op; ordy32 = 1'b0;
        end
        @(posedge clk);
        #1;
        // Scramble operands after acceptance; the result must not depend on them.
        iv8 = 1'b0; iv32 = 1'b0;
        a32 = $urandom; b32 = $urandom; op32 = 4'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom);
        lat = 0;
        while (!(sel ? ov8 : ov32) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(elat));
        check({name, " alu_f"}, sel ? 64'(f8) : 64'(f32), 64'(ef));
        check({name, " flags zscv"}, sel ? 64'({zf8, sf8, cf8, of8}) : 64'({zf32, sf32, cf32, of32}),
              64'(efl));
        @(negedge clk);
        if (sel) ordy8 = 1'b1; else ordy32 = 1'b1;
        @(posedge clk);
        #1;
        ordy8 = 1'b0; ordy32 = 1'b0;
        check({name, " release valid/ready"}, sel ? 64'({ov8, ir8}) : 64'({ov32, ir32}), 64'd1);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] f;
        logic [3:0]  fl;   // {zf, sf, cf, of}
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [35:0] e;
        logic [31:0] hold_f;
        logic [3:0]  op;
        logic [31:0] a, b;
        int          stray;

        vecs.push_back('{"add ovf",    4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 0});
        vecs.push_back('{"add carry",  4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 0});
        vecs.push_back('{"sub 0-1",    4'h8, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0110, 0});
        vecs.push_back('{"sub ovf",    4'h8, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 0});
        vecs.push_back('{"sra",        4'hD, 32'h80000000, 32'h00000024, 32'hF8000000, 4'b0100, 0});
        vecs.push_back('{"sll",        4'h1, 32'h00000001, 32'h00000021, 32'h00000002, 4'b0000, 0});
        vecs.push_back('{"slt",        4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 0});
        vecs.push_back('{"sltu",       4'h3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1000, 0});
        vecs.push_back('{"op1110",     4'hE, 32'h00000005, 32'h00000003, 32'h00000000, 4'b1000, 0});
        vecs.push_back('{"mul ones",   4'h9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 32});
        vecs.push_back('{"mulhu ones", 4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 32});
        vecs.push_back('{"divu 100/7", 4'hB, 32'd100,      32'd7,        32'd14,       4'b0000, 32});
        vecs.push_back('{"remu 100/7", 4'hC, 32'd100,      32'd7,        32'd2,        4'b0000, 32});
        vecs.push_back('{"divu 5/0",   4'hB, 32'd5,        32'd0,        32'hFFFFFFFF, 4'b0100, 32});
        vecs.push_back('{"remu 5/0",   4'hC, 32'd5,        32'd0,        32'd5,        4'b0000, 32});

        iv32 = 0; ordy32 = 0; a32 = 0; b32 = 0; op32 = 0;
        iv8 = 0; ordy8 = 0; a8 = 0; b8 = 0; op8 = 0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset out32", 64'({ov32, f32, zf32, sf32, cf32, of32}), 64'd0);
        check("reset out8", 64'({ov8, f8, zf8, sf8, cf8, of8}), 64'd0);
        rst = 1'b0;
        #1;
        check("reset in_ready", 64'({ir32, ir8}), 64'd3);

        foreach (vecs[i]) begin
            txn(1'b0, vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].fl,
                vecs[i].lat);
        end

        // out_ready held high: DONE lasts exactly one cycle
        @(negedge clk);
        ordy32 = 1'b1; iv32 = 1'b1; op32 = 4'h0; a32 = 32'd3; b32 = 32'd4;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        check("fast done valid", 64'({ov32, f32}), {31'd0, 1'b1, 32'd7});
        @(posedge clk);
        #1;
        check("fast done leave", 64'({ov32, ir32}), 64'd1);
        ordy32 = 1'b0;

        // Stall in DONE: result held, new input ignored
        @(negedge clk);
        iv32 = 1'b1; op32 = 4'hB; a32 = 32'd100; b32 = 32'd7;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        stray = 0;
        while (!ov32 && stray < 100) begin
            @(posedge clk);
            #1;
            stray++;
        end
        check("stall latency", 64'(stray), 64'd32);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            iv32 = 1'b1; op32 = 4'h0; a32 = 32'd1; b32 = 32'd1;
            @(posedge clk);
            #1;
            check("stall hold", 64'({ov32, ir32, zf32, sf32, cf32, of32, f32}),
                  {26'd0, 6'b100000, 32'd14});
        end
        @(negedge clk);
        iv32 = 1'b0; ordy32 = 1'b1;
        @(posedge clk);
        #1;
        ordy32 = 1'b0;
        check("stall release", 64'({ov32, ir32}), 64'd1);
        @(posedge clk);
        #1;
        check("stall no accept", 64'({ov32, ir32}), 64'd1);

        // Reset mid-BUSY aborts the op
        @(negedge clk);
        iv32 = 1'b1; op32 = 4'hB; a32 = 32'd1000; b32 = 32'd3;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort reset out", 64'({ov32, f32, zf32, sf32, cf32, of32}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort in_ready", 64'(ir32), 64'd1);
        stray = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ov32) stray++;
        end
        check("abort stray valid", 64'(stray), 64'd0);

        // 8-bit instance
        txn(1'b1, "w8 mul", 4'h9, 32'hFF, 32'h02, 32'hFE, 4'b0100, 8);
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom);
            a  = 32'($urandom_range(0, 255));
            b  = (i % 6 == 0) ? 32'd0 : 32'($urandom_range(0, 255));
            e  = model(8, op, 64'(a), 64'(b));
            txn(1'b1, $sformatf("w8 rnd%0d op%0h", i, op), op, a, b, e[31:0], e[35:32],
                exp_lat(8, op));
        end

        // Randomized 32-bit ops against the model
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom);
            a  = (i % 9 == 0) ? 32'hFFFFFFFF : $urandom;
            b  = (i % 7 == 0) ? 32'd0 : ((i % 5 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            e  = model(32, op, 64'(a), 64'(b));
            txn(1'b0, $sformatf("w32 rnd%0d op%0h", i, op), op, a, b, e[31:0], e[35:32],
                exp_lat(32, op));
        end

        hold_f = f32;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
